// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer: start/done CORDIC shift-index scheduler; hyperbolic repeats (k=4,13,40,..) under CORDIC_HYP_REP_EN.
// Latency: first step visible the cycle after start; backpressure: stall freezes every output until the step is accepted.
module cordic_iter_sequencer #(
  parameter int N_ITER = 16,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             stall,
  output logic             busy,
  output logic             iter_valid,
  output logic [IDX_W-1:0] shift_idx,
  output logic             rep_flag,
  output logic             first,
  output logic             last,
  output logic [IDX_W-1:0] step_cnt,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             last_start;
  logic             last_nxt;

  assign start_idx = {{(IDX_W-1){1'b0}}, mode};

`ifdef CORDIC_HYP_REP_EN
  localparam logic [IDX_W+1:0] REP_FIRST = (IDX_W+2)'(4);
  localparam logic [IDX_W+1:0] REP_ONE   = (IDX_W+2)'(1);

  logic             hyp_q;
  logic [IDX_W+1:0] next_rep;
  logic [IDX_W+1:0] nrep_nxt;
  logic             rep_nxt;
  logic             rep_hit;

  // next_rep carries two extra bits so 3k+1 never wraps below a reachable index
  always_comb begin
    rep_hit    = hyp_q && !rep_flag && ({2'b00, shift_idx} == next_rep);
    idx_nxt    = rep_hit ? shift_idx : shift_idx + IDX_ONE;
    rep_nxt    = rep_hit;
    nrep_nxt   = rep_flag ? (next_rep << 1) + next_rep + REP_ONE : next_rep;
    last_nxt   = (idx_nxt == LAST_IDX) &&
                 (!hyp_q || rep_nxt || ({2'b00, idx_nxt} != nrep_nxt));
    last_start = (start_idx == LAST_IDX) &&
                 (!mode || ({2'b00, start_idx} != REP_FIRST));
  end
`else
  assign rep_flag = 1'b0;

  always_comb begin
    idx_nxt    = shift_idx + IDX_ONE;
    last_nxt   = (idx_nxt == LAST_IDX);
    last_start = (start_idx == LAST_IDX);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      iter_valid <= 1'b0;
      shift_idx  <= '0;
      first      <= 1'b0;
      last       <= 1'b0;
      step_cnt   <= '0;
      done       <= 1'b0;
`ifdef CORDIC_HYP_REP_EN
      hyp_q      <= 1'b0;
      rep_flag   <= 1'b0;
      next_rep   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            iter_valid <= 1'b1;
            shift_idx  <= start_idx;
            first      <= 1'b1;
            last       <= last_start;
            step_cnt   <= '0;
`ifdef CORDIC_HYP_REP_EN
            hyp_q      <= mode;
            rep_flag   <= 1'b0;
            next_rep   <= REP_FIRST;
`endif
          end
        end
        S_RUN: begin
          if (!stall) begin
            step_cnt <= step_cnt + IDX_ONE;
            first    <= 1'b0;
            if (last) begin
              state      <= S_DONE;
              iter_valid <= 1'b0;
              last       <= 1'b0;
              done       <= 1'b1;
`ifdef CORDIC_HYP_REP_EN
              rep_flag   <= 1'b0;
`endif
            end else begin
              shift_idx <= idx_nxt;
              last      <= last_nxt;
`ifdef CORDIC_HYP_REP_EN
              rep_flag  <= rep_nxt;
              next_rep  <= nrep_nxt;
`endif
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          shift_idx <= '0;
          step_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Scoreboard bench for cordic_iter_sequencer: stimulus queues expected steps, a negedge monitor pops and compares.
module tb_cordic_iter_sequencer;

  localparam int N_ITER = 16;
  localparam int IDX_W  = 5;
`ifdef CORDIC_HYP_REP_EN
  localparam int HYP_STEPS = 17;
`else
  localparam int HYP_STEPS = 15;
`endif

  logic             clk = 1'b0;
  logic             rst, start, mode, stall;
  logic             busy, iter_valid, rep_flag, first, last, done;
  logic [IDX_W-1:0] shift_idx, step_cnt;

  cordic_iter_sequencer #(.N_ITER(N_ITER), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
    .busy(busy), .iter_valid(iter_valid), .shift_idx(shift_idx),
    .rep_flag(rep_flag), .first(first), .last(last),
    .step_cnt(step_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic             is_done;
    logic [IDX_W-1:0] idx;
    logic             rep;
    logic             first;
    logic             last;
    logic [IDX_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int done_cyc = -1;
  int done_seen = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_step(input int idx, input int rep, input int fst, input int lst, input int cnt);
    exp_t e;
    e.is_done = 1'b0;
    e.idx     = IDX_W'(idx);
    e.rep     = (rep != 0);
    e.first   = (fst != 0);
    e.last    = (lst != 0);
    e.cnt     = IDX_W'(cnt);
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e = '0;
    e.is_done = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_circ();
    for (int i = 0; i < 16; i++) push_step(i, 0, i == 0, i == 15, i);
    push_done();
  endtask

  // 1,2,3,4,4r,5..13,13r,14,15 with repeats; 1..15 without
  task automatic push_hyp();
    int cnt;
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      push_step(i, 0, cnt == 0, i == 15, cnt);
      cnt++;
`ifdef CORDIC_HYP_REP_EN
      if (i == 4 || i == 13) begin
        push_step(i, 1, 0, 0, cnt);
        cnt++;
      end
`endif
    end
    push_done();
  endtask

  always @(negedge clk) begin
    if (iter_valid === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'({iter_valid, done}), 64'(0));
      end else if (iter_valid && stall) begin
        check("stall_hold",
              64'({busy, shift_idx, rep_flag, first, last, step_cnt}),
              64'({1'b1, q[0].idx, q[0].rep, q[0].first, q[0].last, q[0].cnt}));
      end else begin
        mon_e = q.pop_front();
        if (mon_e.is_done) begin
          check("done_pulse", 64'({iter_valid, done, busy}), 64'(3'b011));
          done_cyc = cyc;
          done_seen++;
        end else begin
          check("step",
                64'({iter_valid, done, busy, shift_idx, rep_flag, first, last, step_cnt}),
                64'({3'b101, mon_e.idx, mon_e.rep, mon_e.first, mon_e.last, mon_e.cnt}));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    mode      = m;
    start     = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start     = 1'b0;
    mode      = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'(q.size()), 64'(0));
    tick();
    check("idle_after", 64'({busy, iter_valid, done}), 64'(0));
  endtask

  task automatic wait_idx(input int v);
    int n;
    n = 0;
    while (shift_idx != IDX_W'(v) && n < 60) begin
      tick();
      n++;
    end
    check("reach_idx", 64'(shift_idx), 64'(v));
  endtask

  task automatic check_reset_vals(input string name);
    check(name, 64'({busy, iter_valid, shift_idx, rep_flag, first, last, step_cnt, done}), 64'(0));
  endtask

  initial begin
    int seen_before;
    rst   = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    check_reset_vals("reset_vals");
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("idle_no_valid", 64'({busy, iter_valid, done}), 64'(0));

    push_circ();
    do_start(1'b0);
    wait_drain("circ_drain");
    check("circ_done_latency", 64'(done_cyc - start_cyc), 64'(16));

    push_hyp();
    do_start(1'b1);
    wait_drain("hyp_drain");
    check("hyp_done_latency", 64'(done_cyc - start_cyc), 64'(HYP_STEPS));

    push_circ();
    do_start(1'b0);
    wait_idx(7);
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_drain("stall_drain");
    check("stall_done_latency", 64'(done_cyc - start_cyc), 64'(19));

    for (int i = 0; i <= 5; i++) push_step(i, 0, i == 0, 0, i);
    seen_before = done_seen;
    do_start(1'b0);
    wait_idx(2);
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    wait_idx(5);
    rst = 1'b1;
    tick();
    check_reset_vals("midrun_reset_vals");
    rst = 1'b0;
    repeat (4) tick();
    check("rst_queue_empty", 64'(q.size()), 64'(0));
    check("no_done_after_rst", 64'(done_seen), 64'(seen_before));

    push_circ();
    do_start(1'b0);
    wait_drain("restart_drain");
    check("restart_done_latency", 64'(done_cyc - start_cyc), 64'(16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
